clock_gen_multi: RTL and testbench
==================================

Name: clock_gen_multi

Overview:
- Parametrised successor to the fixed divide-by-2 clock divider used to derive the imem/dmem/regfile/processor clocks.
- Generates NUM_CH independent divided clocks from one master clock. Each channel has a runtime-programmable integer ratio and a polarity bit, plus a one-cycle rising-edge strobe usable as a clock enable.
- Ratio and polarity changes take effect glitch-free at a period boundary.
- A global sync request realigns all channels so their rising edges coincide.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- DIV_W, 8, width of the divide-ratio field; legal ratio 2..2^DIV_W-1.
- CH_W, 2, channel-select width = max(1, clog2(NUM_CH)).
- DEF_DIV, 2, ratio loaded into every channel at reset.
- DEF_INV, 0, polarity loaded into every channel at reset.

Ports:
- clock  in  1  master clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cfg_valid  in  1  configuration request.
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  DIV_W  requested ratio N.
- cfg_inv  in  1  requested polarity.
- cfg_ready  out  1  combinational; high when channel cfg_ch has no pending update.
- cfg_err  out  1  registered one-cycle pulse: illegal request rejected.
- sync_req  in  1  realign all channels.
- clk_out  out  NUM_CH  divided clocks, driven directly from flops.
- rise_stb  out  NUM_CH  one-cycle pulse in the cycle where clk_out[i] (non-inverted sense) goes high.

Behaviour:
- Per-channel state:
  - cnt (DIV_W bits).
  - cur_div, cur_inv.
  - pend_div, pend_inv, pend_vld.
- Counting: on each edge cnt <= (cnt == cur_div-1) ? 0 : cnt+1. The wrap edge is the period boundary.
- Output: clk_out registered as cur_inv XOR (cnt_next < ceil(N/2)). High time is ceil(N/2) cycles and low time is floor(N/2) cycles.
  - N=2: 1/1. N=3: 2/1. N=5: 3/2.
- rise_stb[i] is registered, high exactly in the cycle where cnt_next == 0. It ignores inversion.
- Reset (reset==0, asynchronous):
  - cnt = DEF_DIV-1; cur_div = DEF_DIV; cur_inv = DEF_INV; pend_vld = 0.
  - clk_out = DEF_INV; rise_stb = 0; cfg_err = 0.
  - The first edge after reset release produces the rising edge on every channel simultaneously.
  - Reset mid-period discards pending configs and truncates the current period.
- Config acceptance: a request is accepted when cfg_valid and cfg_ready, and cfg_div >= 2 and cfg_ch < NUM_CH.
  - On acceptance, pend_* is written and pend_vld is set.
  - If cfg_div < 2 or cfg_ch >= NUM_CH: no state change; cfg_err pulses next cycle.
  - If cfg_ready is low: no state change, no error. The requester must hold the request.
- Apply: at the channel's wrap edge with pend_vld set, cur_div/cur_inv <= pend_*, pend_vld <= 0, and cnt <= 0. The new period uses the new N and polarity from its first cycle.
  - The period in progress is never shortened or extended.
- Simultaneous accept and wrap on the same channel: the new value is written to pend and applied at the following wrap, not the current one.
- sync_req: on that edge every channel loads pending values if present (as at a wrap), sets cnt = cur_div-1 with the post-load div, and drives clk_out = cur_inv with rise_stb = 0.
  - The next edge gives a common rise on all channels.
- sync_req with a simultaneous cfg accept: sync consumes the older pending value first. The new request then becomes pending for the next wrap.
- No combinational path from any input to clk_out or rise_stb.

Decomposition:
- Shared package clock_gen_pkg holds:
  - DIV_W default and MIN_DIV=2.
  - A cfg record typedef {div, inv}.
  - The ceil-half helper function.
- Sub-module clk_div_channel: one channel's counter, pending register, apply logic and output flops. It is instantiated NUM_CH times under a generate.
- The top level holds the cfg decode, cfg_ready mux, cfg_err flop and sync fan-out.

Test Plan:
- Reset release with DEF_DIV=2, DEF_INV=0: all clk_out toggle every cycle, rise together on the first edge; rise_stb high on alternating cycles.
- cfg ch1 div=5 mid-period: the old period completes, then clk_out[1] is high 3 / low 2 cycles. cfg_ready for ch1 is low until the apply edge.
- cfg ch2 div=4 inv=1, then a second cfg to ch2 before wrap: the second is held off by cfg_ready=0. After apply, clk_out[2] is low 2 / high 2 cycles and rise_stb marks the non-inverted rise.
- cfg_div=1 or cfg_ch=5 with NUM_CH=4: cfg_err pulses once; all outputs unchanged.
- Channels at div 2, 3, 4, 7 free-running, then sync_req: on the next edge all rise_stb bits are high together.
- Assert reset mid-period with a pending cfg on ch0: outputs go to DEF_INV immediately; after release ch0 runs at DEF_DIV and the pending value is lost.

Source files
------------

// File: rtl/clock_gen_pkg.sv
// Shared definitions for the multi-channel clock generator: default field
// widths, the smallest legal divide ratio, the configuration record and the
// half-period helper used to place the high/low split of every period.
package clock_gen_pkg;

  // Default width of the divide-ratio field.
  localparam int DIV_W_DEF = 8;

  // Smallest ratio that still produces a proper high and low phase.
  localparam int MIN_DIV = 2;

  // One channel configuration at the default ratio width.
  typedef struct packed {
    logic [DIV_W_DEF-1:0] div;
    logic                 inv;
  } cfg_t;

  // ceil(n/2): number of high cycles in a period of n master cycles.
  function automatic logic [31:0] ceil_half(input logic [31:0] n);
    return (n >> 1) + {31'd0, n[0]};
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divided-clock channel: period counter, single-entry pending
// configuration, boundary-aligned apply and registered clock/strobe outputs.
// A new ratio or polarity only ever takes effect at a wrap edge or on a sync
// request, so the period in progress is never shortened or stretched.
module clk_div_channel
  import clock_gen_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = 2,
  parameter bit DEF_INV = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_we_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             cfg_inv_i,
  input  logic             sync_i,
  output logic             busy_o,
  output logic             clk_o,
  output logic             stb_o
);

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic             inv;
  } ch_cfg_t;

  ch_cfg_t          cur_q;
  ch_cfg_t          cur_d;
  ch_cfg_t          pend_q;
  ch_cfg_t          pend_d;
  logic             pend_vld_q;
  logic             pend_vld_d;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             clk_q;
  logic             clk_d;
  logic             stb_q;
  logic             stb_d;
  logic [DIV_W-1:0] half_s;
  logic             wrap_s;
  logic             load_s;

  // Next-state logic: counter, apply decision, output levels and pending slot.
  always_comb begin
    // The >= form also pulls an out-of-range count back to a period boundary.
    wrap_s = (cnt_q >= (cur_q.div - DIV_W'(1)));
    load_s = pend_vld_q & (wrap_s | sync_i);

    // The configuration that governs the cycle following this edge.
    if (load_s) begin
      cur_d = pend_q;
    end else begin
      cur_d = cur_q;
    end

    // Sync parks every channel on its last count so the next edge wraps.
    if (sync_i) begin
      cnt_d = cur_d.div - DIV_W'(1);
    end else if (wrap_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    half_s = DIV_W'(ceil_half(32'(cur_d.div)));

    // Low phase (in non-inverted sense) while parked; rise on count zero.
    if (sync_i) begin
      clk_d = cur_d.inv;
      stb_d = 1'b0;
    end else begin
      clk_d = cur_d.inv ^ (cnt_d < half_s);
      stb_d = (cnt_d == '0);
    end

    // A request accepted on an apply edge is kept for the following boundary;
    // the older pending value has already been consumed into cur_d above.
    if (cfg_we_i) begin
      pend_d.div = cfg_div_i;
      pend_d.inv = cfg_inv_i;
      pend_vld_d = 1'b1;
    end else if (load_s) begin
      pend_d     = pend_q;
      pend_vld_d = 1'b0;
    end else begin
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
    end
  end

  // Channel state and output flops; reset discards pending work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= DIV_W'(DEF_DIV - 1);
      cur_q.div  <= DIV_W'(DEF_DIV);
      cur_q.inv  <= DEF_INV;
      pend_q.div <= DIV_W'(DEF_DIV);
      pend_q.inv <= DEF_INV;
      pend_vld_q <= 1'b0;
      clk_q      <= DEF_INV;
      stb_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      stb_q      <= stb_d;
    end
  end

  assign busy_o = pend_vld_q;
  assign clk_o  = clk_q;
  assign stb_o  = stb_q;

endmodule

// File: rtl/clock_gen_multi.sv
// Multi-channel clock generator top: decodes configuration requests, reports
// readiness of the addressed channel, flags illegal requests and fans the
// sync request out to every channel instance.
module clock_gen_multi
  import clock_gen_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int CH_W    = 2,
  parameter int DEF_DIV = 2,
  parameter bit DEF_INV = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_inv,
  output logic              cfg_ready,
  output logic              cfg_err,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_stb
);

  logic [NUM_CH-1:0] busy_s;
  logic [NUM_CH-1:0] sel_s;
  logic [NUM_CH-1:0] we_s;
  logic              ch_ok_s;
  logic              div_ok_s;
  logic              req_s;
  logic              accept_s;
  logic              err_d;
  logic              err_q;

  // Request decode: channel select, legality, readiness and write enables.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_s[i] = (cfg_ch == CH_W'(i));
    end
    // A select that matches no channel is reported ready so it can be rejected.
    ch_ok_s   = |sel_s;
    cfg_ready = ~|(sel_s & busy_s);
    div_ok_s  = (cfg_div >= DIV_W'(MIN_DIV));
    req_s     = cfg_valid & cfg_ready;
    accept_s  = req_s & ch_ok_s & div_ok_s;
    err_d     = req_s & ~(ch_ok_s & div_ok_s);
    we_s      = sel_s & {NUM_CH{accept_s}};
  end

  // One-cycle error pulse following a rejected request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign cfg_err = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV),
      .DEF_INV (DEF_INV)
    ) u_ch (
      .clk_i     (clock),
      .rst_ni    (reset),
      .cfg_we_i  (we_s[g]),
      .cfg_div_i (cfg_div),
      .cfg_inv_i (cfg_inv),
      .sync_i    (sync_req),
      .busy_o    (busy_s[g]),
      .clk_o     (clk_out[g]),
      .stb_o     (rise_stb[g])
    );
  end

endmodule

// File: tb/tb_clock_gen_multi.sv
// Directed bench for clock_gen_multi. Each stimulus step drives one master
// cycle and queues the outputs expected during that cycle; a monitor pops
// and compares at every falling edge. The channel select is one bit wider
// than needed so an out-of-range channel number can be requested.
module tb_clock_gen_multi;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [2:0] cfg_ch = 3'd0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_inv = 1'b0;
  logic       cfg_ready;
  logic       cfg_err;
  logic       sync_req = 1'b0;
  logic [3:0] clk_out;
  logic [3:0] rise_stb;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] clk;
    logic [3:0] stb;
    logic [3:0] msk;
    logic       err;
    logic       rdy;
    string      nm;
  } exp_t;

  exp_t sb_q[$];

  clock_gen_multi #(
    .NUM_CH  (4),
    .DIV_W   (8),
    .CH_W    (3),
    .DEF_DIV (2),
    .DEF_INV (1'b0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_inv   (cfg_inv),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .sync_req  (sync_req),
    .clk_out   (clk_out),
    .rise_stb  (rise_stb)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected while that cycle lasts.
  task automatic step(input logic vld, input logic [2:0] ch, input logic [7:0] dv,
                      input logic iv, input logic sy, input logic rs,
                      input logic [3:0] eclk, input logic [3:0] estb, input logic [3:0] emsk,
                      input logic eerr, input logic erdy, input string nm);
    exp_t e;
    @(posedge clock);
    #1;
    reset     = rs;
    cfg_valid = vld;
    cfg_ch    = ch;
    cfg_div   = dv;
    cfg_inv   = iv;
    sync_req  = sy;
    e.clk = eclk; e.stb = estb; e.msk = emsk; e.err = eerr; e.rdy = erdy; e.nm = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: compare the queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.msk != 4'b0000) begin
          checks++;
          if (((clk_out ^ e.clk) & e.msk) != 4'b0000) begin
            failures++;
            $display("FAIL %s clk_out actual=%b required=%b mask=%b", e.nm, clk_out, e.clk, e.msk);
          end
          checks++;
          if (((rise_stb ^ e.stb) & e.msk) != 4'b0000) begin
            failures++;
            $display("FAIL %s rise_stb actual=%b required=%b mask=%b", e.nm, rise_stb, e.stb, e.msk);
          end
        end
        checks++;
        if (cfg_err !== e.err) begin
          failures++;
          $display("FAIL %s cfg_err actual=%b required=%b", e.nm, cfg_err, e.err);
        end
        checks++;
        if (cfg_ready !== e.rdy) begin
          failures++;
          $display("FAIL %s cfg_ready actual=%b required=%b", e.nm, cfg_ready, e.rdy);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // Stimulus. Cycle labels cN count master cycles after reset release (c0).
  initial begin
    // reset held, then released in c0; all channels at the default ratio 2
    step(0, 3'd0, 8'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1111, 0, 1, "rst_hold0");
    step(0, 3'd0, 8'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1111, 0, 1, "rst_hold1");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 0, 1, "rst_rel");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1111, 4'b1111, 4'b1111, 0, 1, "first_rise");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 0, 1, "div2_c2");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1111, 4'b1111, 4'b1111, 0, 1, "div2_c3");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 0, 1, "div2_c4");
    // ch1 -> ratio 5 requested mid-period (c5), applied at the wrap ending c6
    step(1, 3'd1, 8'd5, 0, 0, 1, 4'b1111, 4'b1111, 4'b1111, 0, 1, "cfg1_req");
    step(0, 3'd1, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 0, 0, "cfg1_pend");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1111, 4'b1111, 4'b1111, 0, 1, "div5_c7");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0010, 4'b0000, 4'b1111, 0, 1, "div5_c8");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1111, 4'b1101, 4'b1111, 0, 1, "div5_c9");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 0, 1, "div5_c10");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1101, 4'b1101, 4'b1111, 0, 1, "div5_c11");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0010, 4'b0010, 4'b1111, 0, 1, "div5_c12");
    // ch2 -> ratio 4 inverted; a held second request (ratio 6) waits for ready
    step(1, 3'd2, 8'd4, 1, 0, 1, 4'b0100, 4'b0100, 4'b0100, 0, 1, "cfg2_req");
    step(1, 3'd2, 8'd6, 0, 0, 1, 4'b0000, 4'b0000, 4'b0100, 0, 0, "cfg2_held");
    step(1, 3'd2, 8'd6, 0, 0, 1, 4'b0000, 4'b0100, 4'b0100, 0, 1, "inv4_c15");
    step(0, 3'd2, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0100, 0, 0, "inv4_c16");
    step(0, 3'd2, 8'd0, 0, 0, 1, 4'b0100, 4'b0000, 4'b0100, 0, 0, "inv4_c17");
    step(0, 3'd2, 8'd0, 0, 0, 1, 4'b0100, 4'b0000, 4'b0100, 0, 0, "inv4_c18");
    step(0, 3'd2, 8'd0, 0, 0, 1, 4'b0100, 4'b0100, 4'b0100, 0, 1, "div6_c19");
    step(0, 3'd2, 8'd0, 0, 0, 1, 4'b0100, 4'b0000, 4'b0100, 0, 1, "div6_c20");
    step(0, 3'd2, 8'd0, 0, 0, 1, 4'b0100, 4'b0000, 4'b0100, 0, 1, "div6_c21");
    step(0, 3'd2, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0100, 0, 1, "div6_c22");
    step(0, 3'd2, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0100, 0, 1, "div6_c23");
    step(0, 3'd2, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0100, 0, 1, "div6_c24");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0100, 4'b0100, 4'b0100, 0, 1, "div6_c25");
    // illegal requests: ratio 1, then channel 5
    step(1, 3'd0, 8'd1, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 1, "err_div_req");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0001, 4'b0001, 4'b0001, 1, 1, "err_div_pulse");
    step(1, 3'd5, 8'd4, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 1, "err_ch_req");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0001, 4'b0001, 4'b0001, 1, 1, "err_ch_pulse");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 1, "err_clear");
    // ch1 -> 3 (accepted on its own wrap edge, so applied one period later),
    // ch2 -> 4, ch3 -> 7; ch0 stays at 2
    step(1, 3'd1, 8'd3, 0, 0, 1, 4'b0000, 4'b0000, 4'b0010, 0, 1, "cfg_ch1_3");
    step(1, 3'd2, 8'd4, 0, 0, 1, 4'b0010, 4'b0010, 4'b0010, 0, 1, "cfg_ch2_4");
    step(1, 3'd3, 8'd7, 0, 0, 1, 4'b0010, 4'b0000, 4'b0010, 0, 1, "cfg_ch3_7");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0010, 4'b0000, 4'b0010, 0, 1, "ch1_c34");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0010, 0, 1, "ch1_c35");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0010, 0, 1, "ch1_c36");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0010, 4'b0010, 4'b0010, 0, 1, "ch1_div3_c37");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0010, 4'b0000, 4'b0010, 0, 1, "ch1_c38");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0010, 0, 1, "ch1_c39");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0010, 4'b0010, 4'b0010, 0, 1, "ch1_c40");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0010, 4'b0000, 4'b0010, 0, 1, "ch1_c41");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0010, 0, 1, "ch1_c42");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0010, 4'b0010, 4'b0010, 0, 1, "ch1_c43");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0010, 4'b0000, 4'b0010, 0, 1, "ch1_c44");
    // sync with ratios 2,3,4,7
    step(0, 3'd0, 8'd0, 0, 1, 1, 4'b0000, 4'b0000, 4'b0010, 0, 1, "sync_req");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 0, 1, "sync_park");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1111, 4'b1111, 4'b1111, 0, 1, "sync_rise");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1110, 4'b0000, 4'b1111, 0, 1, "sync_c48");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1001, 4'b0001, 4'b1111, 0, 1, "sync_c49");
    // sync together with an accept: the new value waits for the next wrap
    step(1, 3'd0, 8'd3, 0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1, "sync_acc_req");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 0, 0, "sync_acc_park");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1111, 4'b1111, 4'b1111, 0, 1, "sync_acc_rise");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1111, 4'b0000, 4'b1111, 0, 1, "sync_acc_c53");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1000, 4'b0000, 4'b1111, 0, 1, "sync_acc_c54");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1011, 4'b0011, 4'b1111, 0, 1, "sync_acc_c55");
    // pending ch0 ratio 4 inverted consumed by sync; concurrent request refused
    step(1, 3'd0, 8'd4, 1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1, "pend_req");
    step(1, 3'd0, 8'd5, 0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, "sync_pend_req");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0001, 4'b0000, 4'b1111, 0, 1, "sync_pend_park");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1110, 4'b1111, 4'b1111, 0, 1, "sync_pend_rise");
    // pending ch0 ratio 7, then reset mid-period
    step(1, 3'd0, 8'd7, 0, 0, 1, 4'b1110, 4'b0000, 4'b1111, 0, 1, "rst_pend_req");
    step(0, 3'd0, 8'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1111, 0, 1, "rst_mid");
    step(0, 3'd0, 8'd0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1111, 0, 1, "rst_mid_hold");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 0, 1, "rst2_rel");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1111, 4'b1111, 4'b1111, 0, 1, "rst2_rise");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 0, 1, "rst2_c65");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b1111, 4'b1111, 4'b1111, 0, 1, "rst2_c66");
    step(0, 3'd0, 8'd0, 0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 0, 1, "rst2_c67");

    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain queue_left actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
